// File: rtl/fetch_buffer_pkg.sv
// Shared constants and types for the instruction fetch buffer.
//   EXC_NONE / EXC_ADEL : exception codes carried with each fetched entry
//   PC_BASE / PC_LIMIT  : legal instruction address window
//   entry_t             : one buffered fetch entry (pc, instr, exccode, bd)
package fetch_buffer_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned COUNT_W = 2;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [XLEN-1:0] PC_BASE  = 32'h0000_3000;
  localparam logic [XLEN-1:0] PC_LIMIT = 32'h0000_6ffc;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [EXC_W-1:0] exccode;
    logic             bd;
  } entry_t;

  // Address fault test used by the fetch stage that produces in_err.
  function automatic logic pc_fault(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < PC_BASE) || (pc > PC_LIMIT);
  endfunction

  // Faulting fetches are replaced by a NOP tagged with an address-load exception.
  function automatic entry_t make_entry(input logic [XLEN-1:0] pc,
                                        input logic [XLEN-1:0] instr,
                                        input logic            err,
                                        input logic            bd);
    entry_t e;
    e.pc      = pc;
    e.bd      = bd;
    e.instr   = err ? INSTR_NOP : instr;
    e.exccode = err ? EXC_ADEL : EXC_NONE;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry fetch buffer between instruction fetch and decode.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : fetch-side handshake; in_ready depends on occupancy only
//   in_pc, in_instr   : fetched entry payload
//   in_err, in_bd     : address fault flag, branch-delay-slot flag
//   out_ready         : decode consumes the head entry this cycle
//   flush             : drop all entries (interrupt / ERET), wins over push and pop
//   out_valid, out_*  : head entry, all data forced to 0 when empty
//   count             : occupied entries, 0..2
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  input  logic             in_err,
  input  logic             in_bd,
  output logic             in_ready,
  input  logic             out_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [EXC_W-1:0] out_exccode,
  output logic             out_bd,
  output logic [COUNT_W-1:0] count
);

  entry_t              mem_q [2];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [COUNT_W-1:0]  count_q;
  logic                push;
  logic                pop;
  entry_t              head;

  // Handshakes are derived from registered occupancy only.
  assign in_ready  = count_q < COUNT_W'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Storage, pointers and occupancy; pointers are 1 bit so they wrap 1->0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= make_entry(in_pc, in_instr, in_err, in_bd);
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head mux; an empty buffer presents all-zero data.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_exccode = head.exccode;
  assign out_bd      = head.bd;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a random
// stream, all checked against a scoreboard of expected head entries.
module tb_fetch_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_err;
  logic        in_bd;
  logic        in_ready;
  logic        out_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_exccode;
  logic        out_bd;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  fetch_buffer #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_err(in_err), .in_bd(in_bd), .in_ready(in_ready),
    .out_ready(out_ready), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_exccode(out_exccode), .out_bd(out_bd), .count(count)
  );

  always #5 clk = ~clk;

  function automatic exp_t expect_entry(input logic [31:0] pc, input logic [31:0] instr,
                                        input logic err, input logic bd);
    exp_t e;
    e.pc    = pc;
    e.bd    = bd;
    e.instr = err ? 32'h0 : instr;
    e.exc   = err ? 5'd4 : 5'd0;
    return e;
  endfunction

  // Drive one cycle, compare the head against the scoreboard, update the model.
  task automatic sb_cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic err, input logic bd, input logic rdy, input logic fl);
    logic can_push;
    in_valid = v; in_pc = pc; in_instr = instr; in_err = err; in_bd = bd;
    out_ready = rdy; flush = fl;
    #1;
    checks++;
    if (count !== 2'(exp_q.size())) begin
      errors++;
      $display("FAIL sb_count: got %0d expected %0d", count, exp_q.size());
    end
    checks++;
    if (in_ready !== (exp_q.size() < 2)) begin
      errors++;
      $display("FAIL sb_in_ready: got %b expected %b", in_ready, exp_q.size() < 2);
    end
    checks++;
    if (exp_q.size() != 0) begin
      if (out_valid !== 1'b1 || {out_pc, out_instr, out_exccode, out_bd} !== exp_q[0]) begin
        errors++;
        $display("FAIL sb_head: got v=%b %h expected v=1 %h", out_valid,
                 {out_pc, out_instr, out_exccode, out_bd}, exp_q[0]);
      end
    end else begin
      if (out_valid !== 1'b0 || {out_pc, out_instr, out_exccode, out_bd} !== 70'h0) begin
        errors++;
        $display("FAIL sb_empty: got v=%b %h expected v=0 zero data", out_valid,
                 {out_pc, out_instr, out_exccode, out_bd});
      end
    end
    can_push = exp_q.size() < 2;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && can_push) exp_q.push_back(expect_entry(pc, instr, err, bd));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    sb_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) idle(1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_err = 1'b0;
    in_bd = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got count=%0d in_ready=%b out_valid=%b expected 0 1 0",
               count, in_ready, out_valid);
    end
    checks++;
    if ({out_pc, out_instr, out_exccode, out_bd} !== 70'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {out_pc, out_instr, out_exccode, out_bd});
    end
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single();
    sb_cycle(1'b1, 32'h3000, 32'h2401_0001, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== 32'h2401_0001 ||
        out_exccode !== 5'd0) begin
      errors++;
      $display("FAIL single_head: got v=%b pc=%h instr=%h exc=%0d expected 1 3000 24010001 0",
               out_valid, out_pc, out_instr, out_exccode);
    end
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drained: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_full();
    sb_cycle(1'b1, 32'h3000, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_cycle(1'b1, 32'h3004, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got count=%0d in_ready=%b expected 2 0", count, in_ready);
    end
    sb_cycle(1'b1, 32'h3008, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    // Pop while full: the concurrent push must still be refused.
    sb_cycle(1'b1, 32'h300c, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd1 || out_pc !== 32'h3004) begin
      errors++;
      $display("FAIL full_pop_order: got count=%0d pc=%h expected 1 3004", count, out_pc);
    end
    drain();
  endtask

  task automatic test_push_pop();
    sb_cycle(1'b1, 32'h3004, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_cycle(1'b1, 32'h3008, 32'h6, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd1 || out_pc !== 32'h3008) begin
      errors++;
      $display("FAIL push_pop: got count=%0d pc=%h expected 1 3008", count, out_pc);
    end
    drain();
  endtask

  task automatic test_err();
    sb_cycle(1'b1, 32'h3002, 32'hffff_ffff, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_instr !== 32'h0 || out_exccode !== 5'd4 || out_pc !== 32'h3002) begin
      errors++;
      $display("FAIL err_entry: got pc=%h instr=%h exc=%0d expected 3002 0 4",
               out_pc, out_instr, out_exccode);
    end
    drain();
  endtask

  task automatic test_flush();
    sb_cycle(1'b1, 32'h3010, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_cycle(1'b1, 32'h3014, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_cycle(1'b1, 32'h3018, 32'h9, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 ||
        {out_pc, out_instr, out_exccode, out_bd} !== 70'h0) begin
      errors++;
      $display("FAIL flush: got count=%0d v=%b data=%h expected 0 0 0", count, out_valid,
               {out_pc, out_instr, out_exccode, out_bd});
    end
    // Pointers restart cleanly after a flush.
    sb_cycle(1'b1, 32'h301c, 32'ha, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      sb_cycle(1'b1, 32'h3100 + 32'(i * 4), 32'h1000 + 32'(i), 1'b0, i[0], 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    sb_cycle(1'b1, 32'h3020, 32'hb, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_cycle(1'b1, 32'h3024, 32'hc, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {out_pc, out_instr, out_exccode, out_bd} !== 70'h0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d v=%b rdy=%b data=%h expected 0 0 1 0",
               count, out_valid, in_ready, {out_pc, out_instr, out_exccode, out_bd});
    end
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      sb_cycle(1'($urandom_range(0, 1)), 32'h3000 + 32'($urandom_range(0, 4095)),
               $urandom, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_push_pop();
    test_err();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
